regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source writeback arbiter feeding a single register-file write port
module regfile_wb_arbiter #(
    parameter int ADDR_SIZE = 5,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [XLEN-1:0]      req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [XLEN-1:0]      req1_data,
    output logic                 wr_en,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [XLEN-1:0]      wr_data,
    input  logic [ADDR_SIZE-1:0] chk_addr1,
    input  logic [ADDR_SIZE-1:0] chk_addr2,
    output logic                 chk_busy1,
    output logic                 chk_busy2
);

    logic                 buf0_full;
    logic [ADDR_SIZE-1:0] buf0_addr;
    logic [XLEN-1:0]      buf0_data;
    logic                 buf1_full;
    logic [ADDR_SIZE-1:0] buf1_addr;
    logic [XLEN-1:0]      buf1_data;
    logic                 prio;
    logic                 grant0;
    logic                 grant1;
    logic                 prio_toggle;
    logic                 acc0;
    logic                 acc1;

    // Equal-address ties go to buf0 without touching prio so the two writes land in a fixed order.
    always_comb begin
        grant0      = 1'b0;
        grant1      = 1'b0;
        prio_toggle = 1'b0;
        if (buf0_full && buf1_full) begin
            if (buf0_addr == buf1_addr) begin
                grant0 = 1'b1;
            end else begin
                prio_toggle = 1'b1;
                if (prio) grant1 = 1'b1;
                else      grant0 = 1'b1;
            end
        end else if (buf0_full) begin
            grant0 = 1'b1;
        end else if (buf1_full) begin
            grant1 = 1'b1;
        end
    end

    assign req0_ready = rst && (!buf0_full || grant0);
    assign req1_ready = rst && (!buf1_full || grant1);
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf0_full <= 1'b0;
            buf0_addr <= '0;
            buf0_data <= '0;
            buf1_full <= 1'b0;
            buf1_addr <= '0;
            buf1_data <= '0;
            prio      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            // Writes to x0 are swallowed at acceptance so they never occupy a buffer.
            if (acc0) begin
                buf0_full <= (req0_addr != '0);
                buf0_addr <= req0_addr;
                buf0_data <= req0_data;
            end else if (grant0) begin
                buf0_full <= 1'b0;
            end
            if (acc1) begin
                buf1_full <= (req1_addr != '0);
                buf1_addr <= req1_addr;
                buf1_data <= req1_data;
            end else if (grant1) begin
                buf1_full <= 1'b0;
            end
            if (prio_toggle) prio <= ~prio;
            wr_en <= grant0 || grant1;
            if (grant0) begin
                wr_addr <= buf0_addr;
                wr_data <= buf0_data;
            end else if (grant1) begin
                wr_addr <= buf1_addr;
                wr_data <= buf1_data;
            end
        end
    end

    assign chk_busy1 = (chk_addr1 != '0) &&
                       ((buf0_full && (buf0_addr == chk_addr1)) ||
                        (buf1_full && (buf1_addr == chk_addr1)) ||
                        (wr_en && (wr_addr == chk_addr1)));
    assign chk_busy2 = (chk_addr2 != '0) &&
                       ((buf0_full && (buf0_addr == chk_addr2)) ||
                        (buf1_full && (buf1_addr == chk_addr2)) ||
                        (wr_en && (wr_addr == chk_addr2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  chk_addr1, chk_addr2;
    logic        chk_busy1, chk_busy2;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.ADDR_SIZE(5), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        chk_addr1 = 5'd5;
        chk_addr2 = 5'd0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_busy1", {31'd0, chk_busy1}, 32'd0);
        chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);

        // single write, two-cycle latency
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        chk("single_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("single_lat1_wr_en", {31'd0, wr_en}, 32'd0);
        step();
        chk("single_wr_en", {31'd0, wr_en}, 32'd1);
        chk("single_wr_addr", {27'd0, wr_addr}, 32'd5);
        chk("single_wr_data", wr_data, 32'hDEADBEEF);
        step();
        chk("single_after_wr_en", {31'd0, wr_en}, 32'd0);
        chk("single_hold_addr", {27'd0, wr_addr}, 32'd5);
        chk("single_hold_data", wr_data, 32'hDEADBEEF);

        // hazard query on addr 9
        chk_addr1 = 5'd9;
        drive(1, 5'd9, 32'h99, 0, 0, 0);
        chk("haz_busy_pre", {31'd0, chk_busy1}, 32'd0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("haz_busy_buf", {31'd0, chk_busy1}, 32'd1);
        step();
        chk("haz_wr_addr", {27'd0, wr_addr}, 32'd9);
        chk("haz_busy_wr", {31'd0, chk_busy1}, 32'd1);
        step();
        chk("haz_busy_done", {31'd0, chk_busy1}, 32'd0);
        chk("haz_wr_en_done", {31'd0, wr_en}, 32'd0);

        // x0 writes accepted and discarded
        chk_addr2 = 5'd0;
        drive(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        chk("x0_ready1", {31'd0, req1_ready}, 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("x0_wr_en_%0d", i), {31'd0, wr_en}, 32'd0);
            chk($sformatf("x0_busy2_%0d", i), {31'd0, chk_busy2}, 32'd0);
            step();
        end

        // saturated contention from a fresh reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive(1, 5'd3, 32'h300, 1, 5'd4, 32'h400);
        chk("cont_c0_ready0", {31'd0, req0_ready}, 32'd1);
        chk("cont_c0_ready1", {31'd0, req1_ready}, 32'd1);
        step();
        chk("cont_c1_wr_en", {31'd0, wr_en}, 32'd0);
        chk("cont_c1_ready0", {31'd0, req0_ready}, 32'd1);
        chk("cont_c1_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("cont_wr_en_%0d", k), {31'd0, wr_en}, 32'd1);
            chk($sformatf("cont_addr_%0d", k), {27'd0, wr_addr}, (k % 2 == 0) ? 32'd3 : 32'd4);
            chk($sformatf("cont_data_%0d", k), wr_data, (k % 2 == 0) ? 32'h300 : 32'h400);
            chk($sformatf("cont_ready0_%0d", k), {31'd0, req0_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("cont_ready1_%0d", k), {31'd0, req1_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k < 5) step();
        end

        // reset with both buffers full
        chk_addr1 = 5'd3;
        chk_addr2 = 5'd4;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
        step();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid_rst_wr_en_%0d", i), {31'd0, wr_en}, 32'd0);
            chk($sformatf("mid_rst_busy1_%0d", i), {31'd0, chk_busy1}, 32'd0);
            chk($sformatf("mid_rst_busy2_%0d", i), {31'd0, chk_busy2}, 32'd0);
            step();
        end

        // prio back at 0: source 0 wins first, leaving prio=1
        drive(1, 5'd3, 32'h31, 1, 5'd4, 32'h41);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("prio0_first_addr", {27'd0, wr_addr}, 32'd3);
        chk("prio0_first_data", wr_data, 32'h31);
        step();
        chk("prio0_second_addr", {27'd0, wr_addr}, 32'd4);
        chk("prio0_second_data", wr_data, 32'h41);
        step();

        // same-address tie with prio=1: buf0 first, prio untouched
        drive(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("tie_first_en", {31'd0, wr_en}, 32'd1);
        chk("tie_first_addr", {27'd0, wr_addr}, 32'd7);
        chk("tie_first_data", wr_data, 32'h1);
        step();
        chk("tie_second_en", {31'd0, wr_en}, 32'd1);
        chk("tie_second_data", wr_data, 32'h2);
        step();
        chk("tie_idle_en", {31'd0, wr_en}, 32'd0);

        // prio still 1 after the tie: source 1 wins next contention
        drive(1, 5'd3, 32'h32, 1, 5'd4, 32'h42);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("prio1_first_addr", {27'd0, wr_addr}, 32'd4);
        chk("prio1_first_data", wr_data, 32'h42);
        step();
        chk("prio1_second_addr", {27'd0, wr_addr}, 32'd3);
        chk("prio1_second_data", wr_data, 32'h32);
        step();
        chk("final_idle_en", {31'd0, wr_en}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
